// File: rtl/uart_rx_command_controller.sv
// UART receive command controller.
// Decodes an opcode byte from the UART receiver, collects its operand bytes
// and issues one-cycle register-file / ALU strobes. Receive errors, unknown
// opcodes and inter-byte timeouts abort the command with a command_error pulse.
module uart_rx_command_controller #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int ALU_FUNCTION_WIDTH = 4,
    parameter int OPERAND_A_ADDRESS  = 0,
    parameter int OPERAND_B_ADDRESS  = 1,
    parameter int TIMEOUT_CYCLES     = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_data_valid,
    input  logic [DATA_WIDTH-1:0]         rx_parallel_data,
    input  logic                          rx_parity_error,
    input  logic                          rx_frame_error,
    input  logic                          command_ready,
    output logic                          register_write_enable,
    output logic                          register_read_enable,
    output logic [ADDRESS_WIDTH-1:0]      register_address,
    output logic [DATA_WIDTH-1:0]         register_write_data,
    output logic                          alu_enable,
    output logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
    output logic                          command_error,
    output logic                          busy
);

    localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [DATA_WIDTH-1:0] OPCODE_WRITE    = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OPCODE_READ     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OPCODE_ALU_OPS  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OPCODE_ALU_ONLY = DATA_WIDTH'(8'hDD);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUNC, ISSUE
    } state_t;

    state_t                          state, next_state;
    logic [COUNT_WIDTH-1:0]          count, next_count;
    logic                            error_level_q;
    logic                            pending_alu, next_pending_alu;
    logic [ADDRESS_WIDTH-1:0]        next_address;
    logic [DATA_WIDTH-1:0]           next_write_data;
    logic [ALU_FUNCTION_WIDTH-1:0]   next_function;
    logic                            next_write_enable, next_read_enable;
    logic                            next_alu_enable, next_command_error;
    logic                            error_event;

    // Rising edge of either receiver error flag; level flags stay high for a whole frame.
    assign error_event = (rx_parity_error | rx_frame_error) & ~error_level_q;

    // State, counter and all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            count                 <= '0;
            error_level_q         <= 1'b0;
            pending_alu           <= 1'b0;
            register_write_enable <= 1'b0;
            register_read_enable  <= 1'b0;
            register_address      <= '0;
            register_write_data   <= '0;
            alu_enable            <= 1'b0;
            alu_function          <= '0;
            command_error         <= 1'b0;
            busy                  <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values.
            state                 <= next_state;
            count                 <= next_count;
            error_level_q         <= rx_parity_error | rx_frame_error;
            pending_alu           <= next_pending_alu;
            register_write_enable <= next_write_enable;
            register_read_enable  <= next_read_enable;
            register_address      <= next_address;
            register_write_data   <= next_write_data;
            alu_enable            <= next_alu_enable;
            alu_function          <= next_function;
            command_error         <= next_command_error;
            busy                  <= (next_state != IDLE);
        end
    end

    // Next-state, timeout and output decode; error events take priority over bytes.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        next_state         = state;
        next_count         = count;
        next_pending_alu   = pending_alu;
        next_address       = register_address;
        next_write_data    = register_write_data;
        next_function      = alu_function;
        next_write_enable  = 1'b0;
        next_read_enable   = 1'b0;
        next_alu_enable    = 1'b0;
        next_command_error = 1'b0;

        if (error_event) begin
            next_command_error = 1'b1;
            next_state         = IDLE;
            next_count         = '0;
        end else begin
            case (state)
                IDLE: begin
                    next_count = '0;
                    if (rx_data_valid) begin
                        case (rx_parallel_data)
                            OPCODE_WRITE:    next_state = WR_ADDR;
                            OPCODE_READ:     next_state = RD_ADDR;
                            OPCODE_ALU_OPS:  next_state = OP_A;
                            OPCODE_ALU_ONLY: next_state = FUNC;
                            default:         next_command_error = 1'b1;
                        endcase
                    end
                end
                ISSUE: begin
                    next_count = '0;
                    // A stray byte is rejected but the pending command survives.
                    if (rx_data_valid) next_command_error = 1'b1;
                    if (command_ready) begin
                        next_state       = IDLE;
                        next_alu_enable  = pending_alu;
                        next_read_enable = ~pending_alu;
                    end
                end
                default: begin
                    if (rx_data_valid) begin
                        next_count = '0;
                        case (state)
                            WR_ADDR: begin
                                next_address = rx_parallel_data[ADDRESS_WIDTH-1:0];
                                next_state   = WR_DATA;
                            end
                            WR_DATA: begin
                                next_write_data   = rx_parallel_data;
                                next_write_enable = 1'b1;
                                next_state        = IDLE;
                            end
                            RD_ADDR: begin
                                next_address     = rx_parallel_data[ADDRESS_WIDTH-1:0];
                                next_pending_alu = 1'b0;
                                next_state       = ISSUE;
                            end
                            OP_A: begin
                                next_address      = ADDRESS_WIDTH'(OPERAND_A_ADDRESS);
                                next_write_data   = rx_parallel_data;
                                next_write_enable = 1'b1;
                                next_state        = OP_B;
                            end
                            OP_B: begin
                                next_address      = ADDRESS_WIDTH'(OPERAND_B_ADDRESS);
                                next_write_data   = rx_parallel_data;
                                next_write_enable = 1'b1;
                                next_state        = FUNC;
                            end
                            FUNC: begin
                                next_function    = rx_parallel_data[ALU_FUNCTION_WIDTH-1:0];
                                next_pending_alu = 1'b1;
                                next_state       = ISSUE;
                            end
                            default: next_state = IDLE;
                        endcase
                    end else if (count == COUNT_LAST) begin
                        next_command_error = 1'b1;
                        next_state         = IDLE;
                        next_count         = '0;
                    end else begin
                        next_count = count + COUNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

endmodule
